// File: rtl/priority_event_encoder.sv
// -----------------------------------------------------------------------------
// priority_event_encoder
//
// Collects request pulses into a sticky pending vector and presents the
// highest-index pending request as a binary code over a valid/ready handshake.
// This is the reverse mapping of a 2-to-4 style binary decoder: bit i of the
// request vector comes back out as code i.
//
// Parameters:
//   N        number of request lines (power of two, N >= 2)
//   W        code width, derived as $clog2(N)
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   en       capture enable; req is ignored while low
//   req      request pulses, any number of bits per cycle
//   code     binary index of the presented request
//   valid    code is valid
//   ready    consumer accepts code when valid && ready
//   pending  registered pending vector
//   ovr      sticky overrun flag (request on an already-pending bit)
//   ovr_clr  synchronous clear of ovr; a simultaneous overrun wins
// -----------------------------------------------------------------------------
module priority_event_encoder #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [W-1:0] code,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pending,
  output logic         ovr,
  input  logic         ovr_clr
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t         state_q;
  logic [N-1:0]   pend_q;
  logic [W-1:0]   code_q;
  logic           valid_q;
  logic           ovr_q;

  logic [N-1:0]   set_d;
  logic           ack_d;
  logic [N-1:0]   clr_d;
  logic [N-1:0]   pend_d;
  logic           ovr_d;
  logic [W-1:0]   msb_d;

  // Highest set bit wins; ascending scan lets later (higher) bits overwrite.
  function automatic logic [W-1:0] msb_index(input logic [N-1:0] p);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (p[i]) idx = W'(i);
    end
    return idx;
  endfunction

  always_comb begin
    set_d  = req & {N{en}};
    ack_d  = valid_q && ready;
    clr_d  = '0;
    if (ack_d) clr_d[code_q] = 1'b1;
    // Set is OR-ed in after the clear, so a re-request in the ack cycle
    // keeps the bit pending.
    pend_d = (pend_q & ~clr_d) | set_d;
    msb_d  = msb_index(pend_d);
    // Overrun only counts hits on bits that stay pending; the set term is
    // evaluated last so it dominates a simultaneous clear request.
    ovr_d  = ovr_q;
    if (ovr_clr) ovr_d = 1'b0;
    if ((set_d & pend_q & ~clr_d) != '0) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      case (state_q)
        IDLE: begin
          if (pend_d != '0) begin
            code_q  <= msb_d;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          // Code is frozen until the consumer takes it, even if a
          // higher-priority request shows up meanwhile.
          if (ack_d) begin
            if (pend_d != '0) begin
              code_q <= msb_d;
            end else begin
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign pending = pend_q;
  assign ovr     = ovr_q;

endmodule

// File: doc/priority_event_encoder.md
Name: priority_event_encoder

Overview:
- Sequential counterpart of the team's 2-to-4 binary decoder: it performs the reverse mapping, N-bit request lines to a W-bit binary code.
- Captures request pulses into a sticky pending vector and presents the highest-index pending request as a binary code.
- Output uses a valid/ready handshake.
- Sits between one-hot event sources (decoder outputs, interrupt-style flags) and a consumer that wants one binary index at a time.

Parameters:
- N, 4, number of request lines; power of two, N >= 2.
- W, $clog2(N), code width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable; when 0, req is ignored.
- req  input  N  request pulses; any number of bits may be high in one cycle.
- code  output  W  binary index of the presented request.
- valid  output  1  code is valid.
- ready  input  1  consumer accepts code when valid && ready.
- pending  output  N  registered pending vector.
- ovr  output  1  sticky overrun flag.
- ovr_clr  input  1  synchronous clear of ovr.

Behaviour:
- Reset: rst_n low immediately (asynchronously) forces pend=0, code=0, valid=0, ovr=0, state=IDLE. Holds while low.
- Reset mid-handshake drops valid at once. After release, the block is in IDLE with nothing pending.
- Definitions:
  - set = req & {N{en}}.
  - ack = valid && ready.
  - clr = onehot(code) when ack, else 0.
- Pending update every edge: pend_next = (pend & ~clr) | set. Set wins over clear on the same bit.
- Priority: highest index wins. Code for bit i is i, so bit i maps back to the decoder input that drives bcode[i].
- States: IDLE and HOLD.
- IDLE:
  - valid=0.
  - If pend_next != 0: code <= msb_index(pend_next), valid <= 1, go to HOLD.
  - Latency: req sampled at edge t gives valid=1 and correct code after edge t (visible in cycle t+1).
- HOLD:
  - valid=1. code stays stable while ready=0, regardless of new requests, including higher-priority ones.
  - On ack with (pend_next != 0): code <= msb_index(pend_next), stay in HOLD. This gives back-to-back transfers with 1 code per cycle.
  - On ack with (pend_next == 0): valid <= 0, go to IDLE.
- Re-request of the bit being acked in the ack cycle: the bit stays pending and is re-presented (as msb if highest).
- Overrun: ovr <= 1 on any edge where (set & pend & ~clr) != 0, i.e. a request arrives on a bit already pending and not being cleared.
  - ovr_clr=1 clears ovr. If overrun and ovr_clr occur in the same cycle, set wins (ovr=1).
  - Overrun does not change pend (bit already 1).
- pending output = registered pend. The bit being presented remains 1 until it is acked.
- en=0: no capture. Already-pending bits are still presented and drained normally.
- Invariants:
  - valid=1 implies pend[code]=1.
  - code only changes on an ack edge or an IDLE-to-HOLD edge.
- Fully synchronous except for the reset. No combinational path from req to the outputs. ready affects only next-state logic.

Test Plan:
- Reset: assert rst_n=0 mid-cycle while valid=1 -> valid=0, code=0, pending=0000, ovr=0 immediately. Release -> all remain 0 with req=0.
- Single event: en=1, req=0100 for 1 cycle, ready=0 -> next cycle valid=1, code=2, pending=0100, stable 5 cycles. Then ready=1 for 1 cycle -> pending=0000, valid=0.
- Multi-event drain: en=1, req=1011 for 1 cycle, ready held 1 -> codes 3,1,0 on 3 consecutive cycles with valid=1, then valid=0, pending=0000.
- Enable gating: en=0, req=1111 for 3 cycles -> pending=0000, valid=0. Then en=1, req=0010 -> valid=1, code=1.
- Overrun and set-wins:
  - req=0001 twice, ready=0 -> ovr=1, code=0, pending=0001.
  - ovr_clr=1 -> ovr=0.
  - In an ack cycle with code=0, req=0001 -> next cycle valid=1, code=0, pending=0001.
- Hold stability: code=1 presented, ready=0, then req=1000 -> code stays 1 until ack. Next cycle code=3.
